clock_divider_bank: RTL

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clock_divider_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of NUM_CLOCKS integer clock dividers sharing one
// startup/realignment sequencer. Every output comes straight from a register.
module clock_divider_bank #(
  parameter int NUM_CLOCKS     = 3,
  parameter int DIV_WIDTH      = 8,
  parameter int STARTUP_CYCLES = 16
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] i_div,
  input  logic                            i_load,
  output logic [NUM_CLOCKS-1:0]           o_clock,
  output logic [NUM_CLOCKS-1:0]           o_tick,
  output logic                            o_valid
);

  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } state_t;

  state_t                 state;
  logic [SW-1:0]          scnt;
  logic [DIV_WIDTH-1:0]   ratio   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   cnt     [NUM_CLOCKS];

  logic [DIV_WIDTH-1:0]   eff_d   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   half_d  [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]   cnt_nxt [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]  active;
  logic [NUM_CLOCKS-1:0]  clk_nxt;
  logic [NUM_CLOCKS-1:0]  tick_nxt;
  logic [NUM_CLOCKS-1:0]  load_on;

  // Per-channel next counter and next output levels; outputs are registered
  // from the next counter value so o_clock always matches the live count.
  always_comb begin
    clk_nxt  = '0;
    tick_nxt = '0;
    active   = '0;
    load_on  = '0;
    for (int unsigned k = 0; k < NUM_CLOCKS; k++) begin
      eff_d[k]   = (ratio[k] == DIV_WIDTH'(1)) ? DIV_WIDTH'(2) : ratio[k];
      // ceil(D/2) without needing an extra bit for D+1
      half_d[k]  = (eff_d[k] >> 1) + {{(DIV_WIDTH-1){1'b0}}, eff_d[k][0]};
      active[k]  = (ratio[k] != '0);
      if (!active[k] || (cnt[k] == eff_d[k] - DIV_WIDTH'(1)))
        cnt_nxt[k] = '0;
      else
        cnt_nxt[k] = cnt[k] + DIV_WIDTH'(1);
      clk_nxt[k]  = active[k] && (cnt_nxt[k] < half_d[k]);
      tick_nxt[k] = active[k] && (cnt_nxt[k] == '0);
      load_on[k]  = (i_div[k*DIV_WIDTH +: DIV_WIDTH] != '0);
    end
  end

  // Sequencer: IDLE -> WAIT (startup settle) -> RUN, with load realignment.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      scnt    <= '0;
      o_clock <= '0;
      o_tick  <= '0;
      o_valid <= 1'b0;
      for (int unsigned k = 0; k < NUM_CLOCKS; k++) begin
        ratio[k] <= '0;
        cnt[k]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          o_clock <= '0;
          o_tick  <= '0;
          o_valid <= 1'b0;
          if (i_enable) begin
            state <= WAIT;
            scnt  <= '0;
          end
        end
        WAIT: begin
          if (!i_enable) begin
            state <= IDLE;
            scnt  <= '0;
          end else if (scnt == LAST) begin
            // Ratios latched here; first RUN cycle has every counter at 0.
            state   <= RUN;
            scnt    <= '0;
            o_valid <= 1'b1;
            o_clock <= load_on;
            o_tick  <= load_on;
            for (int unsigned k = 0; k < NUM_CLOCKS; k++) begin
              ratio[k] <= i_div[k*DIV_WIDTH +: DIV_WIDTH];
              cnt[k]   <= '0;
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        RUN: begin
          if (!i_enable || i_load) begin
            state   <= i_enable ? WAIT : IDLE;
            scnt    <= '0;
            o_clock <= '0;
            o_tick  <= '0;
            o_valid <= 1'b0;
            for (int unsigned k = 0; k < NUM_CLOCKS; k++)
              cnt[k] <= '0;
          end else begin
            o_clock <= clk_nxt;
            o_tick  <= tick_nxt;
            for (int unsigned k = 0; k < NUM_CLOCKS; k++)
              cnt[k] <= cnt_nxt[k];
          end
        end
        default: begin
          state   <= IDLE;
          o_clock <= '0;
          o_tick  <= '0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
